// File: rtl/serial_sub3.sv
// Bit-serial subtractor: D = A - B - BI computed LSB first, one bit per clock,
// with a start/busy/done handshake and results held between operations.
module serial_sub3 #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BI,
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] rSh_q, rSh_d;
    logic             br_q, br_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] D_q, D_d;
    logic             BO_q, BO_d;

    logic aBit, bBit, diffBit, brNext, lastBit;

    assign aBit    = aSh_q[0];
    assign bBit    = bSh_q[0];
    assign diffBit = aBit ^ bBit ^ br_q;
    assign brNext  = (~aBit & bBit) | (~(aBit ^ bBit) & br_q);
    assign lastBit = (state_q == SHIFT) && (count_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (lastBit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operands are captured only on an accepted start; later input changes are ignored.
    always_comb begin
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        rSh_d   = rSh_q;
        br_d    = br_q;
        count_d = count_q;
        D_d     = D_q;
        BO_d    = BO_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    aSh_d   = A;
                    bSh_d   = B;
                    br_d    = BI;
                    rSh_d   = '0;
                    count_d = '0;
                end
            end
            SHIFT: begin
                rSh_d   = {diffBit, rSh_q[WIDTH-1:1]};
                aSh_d   = aSh_q >> 1;
                bSh_d   = bSh_q >> 1;
                br_d    = brNext;
                count_d = count_q + CW'(1);
                if (lastBit) begin
                    D_d  = {diffBit, rSh_q[WIDTH-1:1]};
                    BO_d = brNext;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aSh_q   <= '0;
            bSh_q   <= '0;
            rSh_q   <= '0;
            br_q    <= 1'b0;
            count_q <= '0;
            D_q     <= '0;
            BO_q    <= 1'b0;
        end else begin
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            rSh_q   <= rSh_d;
            br_q    <= br_d;
            count_q <= count_d;
            D_q     <= D_d;
            BO_q    <= BO_d;
        end
    end

    assign D  = D_q;
    assign BO = BO_q;

endmodule

// File: tb/tb_serial_sub3.sv
// Directed bench for serial_sub3: reset, latency, vectors, exhaustive sweep,
// ignored start, asynchronous reset mid-operation and result hold.
module tb_serial_sub3;

    localparam int WIDTH = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BI;
    logic [WIDTH-1:0] D;
    logic             BO;
    logic             busy;
    logic             done;

    int checks;
    int failures;
    int doneCount;

    serial_sub3 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .BI    (BI),
        .D     (D),
        .BO    (BO),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count done pulses and flag any cycle where busy and done overlap.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) doneCount++;
            checks++;
            if (busy === 1'b1 && done === 1'b1) begin
                failures++;
                $display("[TB] FAIL busy_done_overlap busy=%b done=%b required not both 1", busy, done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
        A     = a;
        B     = b;
        BI    = bi;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            cyc++;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        A = '0; B = '0; BI = 1'b0;
        #12;
        checks++; if (D !== 3'b000) begin failures++; $display("[TB] FAIL reset_D got=%b exp=000", D); end
        checks++; if (BO !== 1'b0) begin failures++; $display("[TB] FAIL reset_BO got=%b exp=0", BO); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        startOp(3'd5, 3'd3, 1'b0);
        for (int e = 0; e < WIDTH; e++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL latency_busy edge=%0d busy=%b done=%b exp busy=1 done=0", e, busy, done);
            end
            if (e < WIDTH - 1) tick();
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || D !== 3'b010 || BO !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_done done=%b busy=%b D=%b BO=%b exp done=1 busy=0 D=010 BO=0", done, busy, D, BO);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || D !== 3'b010) begin
            failures++;
            $display("[TB] FAIL latency_after done=%b busy=%b D=%b exp done=0 busy=0 D=010", done, busy, D);
        end
    endtask

    task automatic test_vectors();
        logic [WIDTH-1:0] va [3];
        logic [WIDTH-1:0] vb [3];
        logic             vbi[3];
        logic [WIDTH:0]   vexp[3];
        bit ok;
        int cyc;
        va[0] = 3'd3; vb[0] = 3'd5; vbi[0] = 1'b0; vexp[0] = 4'b1110;
        va[1] = 3'd0; vb[1] = 3'd0; vbi[1] = 1'b1; vexp[1] = 4'b1111;
        va[2] = 3'd7; vb[2] = 3'd7; vbi[2] = 1'b0; vexp[2] = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            startOp(va[i], vb[i], vbi[i]);
            waitDone(ok, cyc);
            checks++;
            if (!ok || cyc != WIDTH || {BO, D} !== vexp[i]) begin
                failures++;
                $display("[TB] FAIL vector%0d ok=%0d cyc=%0d got={%b,%b} exp=%b cyc=%0d", i, ok, cyc, BO, D, vexp[i], WIDTH);
            end
            tick();
        end
    endtask

    task automatic test_sweep();
        bit ok;
        int cyc;
        int startDones;
        logic [WIDTH:0] exp4;
        int sweepFails;
        sweepFails = 0;
        startDones = doneCount;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    exp4 = 4'(a - b - bi);
                    startOp(3'(a), 3'(b), 1'(bi));
                    waitDone(ok, cyc);
                    checks++;
                    if (!ok || {BO, D} !== exp4) begin
                        failures++;
                        sweepFails++;
                        if (sweepFails < 6)
                            $display("[TB] FAIL sweep a=%0d b=%0d bi=%0d ok=%0d got={%b,%b} exp=%b", a, b, bi, ok, BO, D, exp4);
                    end
                    tick();
                end
            end
        end
        checks++;
        if (doneCount - startDones != 128) begin
            failures++;
            $display("[TB] FAIL sweep_done_count got=%0d exp=128", doneCount - startDones);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        int startDones;
        startDones = doneCount;
        startOp(3'd6, 3'd1, 1'b0);
        A     = 3'd1;
        B     = 3'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(ok, cyc);
        checks++;
        if (!ok || cyc != WIDTH - 1 || D !== 3'b101 || BO !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ignored_start ok=%0d cyc=%0d D=%b BO=%b exp cyc=%0d D=101 BO=0", ok, cyc, D, BO, WIDTH - 1);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (doneCount - startDones != 1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ignored_start_dones got=%0d busy=%b exp=1 busy=0", doneCount - startDones, busy);
        end
    endtask

    task automatic test_async_reset();
        int startDones;
        startOp(3'd4, 3'd2, 1'b0);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (D !== 3'b000 || BO !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset D=%b BO=%b busy=%b done=%b exp all 0", D, BO, busy, done);
        end
        #1;
        rst_n = 1'b1;
        tick();
        startDones = doneCount;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (doneCount != startDones || busy !== 1'b0 || D !== 3'b000 || BO !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset_after dones=%0d busy=%b D=%b BO=%b exp dones=0 busy=0 D=000 BO=0",
                     doneCount - startDones, busy, D, BO);
        end
    endtask

    task automatic test_hold();
        bit ok;
        int cyc;
        startOp(3'd2, 3'd7, 1'b1);
        waitDone(ok, cyc);
        checks++;
        if (!ok || D !== 3'b010 || BO !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_result ok=%0d D=%b BO=%b exp D=010 BO=1", ok, D, BO);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            A  = 3'(i);
            B  = 3'(7 - i);
            BI = 1'(i);
            checks++;
            if (D !== 3'b010 || BO !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold cycle=%0d D=%b BO=%b done=%b exp D=010 BO=1 done=0", i, D, BO, done);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        doneCount = 0;
        test_reset();
        test_latency();
        test_vectors();
        test_sweep();
        test_back_to_back();
        test_async_reset();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
